// File: rtl/bgr_stream_packer_if.sv
// Pixel-sum input and byte-stream output handshakes of the BGR packer.
interface bgr_stream_packer_if #(
    parameter int ACC_W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] in_sum_r;
    logic [ACC_W-1:0] in_sum_g;
    logic [ACC_W-1:0] in_sum_b;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_byte;
    logic             out_sof;
    logic             out_eol;
    logic             out_eof;

    modport master (
        output in_valid, in_sum_r, in_sum_g, in_sum_b, out_ready,
        input  in_ready, out_valid, out_byte, out_sof, out_eol, out_eof
    );

    modport slave (
        input  in_valid, in_sum_r, in_sum_g, in_sum_b, out_ready,
        output in_ready, out_valid, out_byte, out_sof, out_eol, out_eof
    );
endinterface

// File: rtl/bgr_stream_packer.sv
// Normalises R/G/B sums to bytes and streams them B,G,R with frame flags.
// Optional clamp counter on sat_count: define BGR_STREAM_PACKER_SATCNT_EN.
module bgr_stream_packer #(
    parameter int ROWS       = 192,
    parameter int COLS       = 192,
    parameter int ACC_W      = 24,
    parameter int NORM_SHIFT = 12
) (
    input  logic                clk,
    input  logic                rst,
    bgr_stream_packer_if.slave  bus,
    output logic                busy
`ifdef BGR_STREAM_PACKER_SATCNT_EN
    ,
    output logic [15:0]         sat_count
`endif
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_B    = 2'd1;
    localparam logic [1:0] S_G    = 2'd2;
    localparam logic [1:0] S_R    = 2'd3;

    logic [1:0]       r_state;
    logic [RW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic [7:0]       r_b_q;
    logic [7:0]       r_g_q;
    logic [7:0]       r_r_q;

    logic [ACC_W-1:0] w_v_b;
    logic [ACC_W-1:0] w_v_g;
    logic [ACC_W-1:0] w_v_r;
    logic             w_clamp_b;
    logic             w_clamp_g;
    logic             w_clamp_r;
    logic             w_accept;
    logic             w_r_done;
    logic             w_row_last;
    logic             w_col_last;

    // Anything above bit 7 after the shift means the channel clamps.
    assign w_v_b     = bus.in_sum_b >> NORM_SHIFT;
    assign w_v_g     = bus.in_sum_g >> NORM_SHIFT;
    assign w_v_r     = bus.in_sum_r >> NORM_SHIFT;
    assign w_clamp_b = |w_v_b[ACC_W-1:8];
    assign w_clamp_g = |w_v_g[ACC_W-1:8];
    assign w_clamp_r = |w_v_r[ACC_W-1:8];

    assign bus.in_ready  = (r_state == S_IDLE) |
                           ((r_state == S_R) & bus.out_ready);
    assign w_accept      = bus.in_valid & bus.in_ready;
    assign w_r_done      = (r_state == S_R) & bus.out_ready;
    assign w_row_last    = (r_row == ROW_LAST);
    assign w_col_last    = (r_col == COL_LAST);

    assign bus.out_valid = (r_state != S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign bus.out_sof   = (r_state == S_B) & (r_row == '0) & (r_col == '0);
    assign bus.out_eol   = (r_state == S_R) & w_col_last;
    assign bus.out_eof   = (r_state == S_R) & w_col_last & w_row_last;

    always_comb begin
        bus.out_byte = 8'h00;
        case (r_state)
            S_B:     bus.out_byte = r_b_q;
            S_G:     bus.out_byte = r_g_q;
            S_R:     bus.out_byte = r_r_q;
            default: bus.out_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_b_q   <= 8'h00;
            r_g_q   <= 8'h00;
            r_r_q   <= 8'h00;
        end else begin
            if (w_accept) begin
                r_b_q <= w_clamp_b ? 8'hFF : w_v_b[7:0];
                r_g_q <= w_clamp_g ? 8'hFF : w_v_g[7:0];
                r_r_q <= w_clamp_r ? 8'hFF : w_v_r[7:0];
            end
            case (r_state)
                S_IDLE:  if (w_accept) r_state <= S_B;
                S_B:     if (bus.out_ready) r_state <= S_G;
                S_G:     if (bus.out_ready) r_state <= S_R;
                S_R:     if (bus.out_ready) r_state <= w_accept ? S_B : S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_r_done) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

`ifdef BGR_STREAM_PACKER_SATCNT_EN
    logic [15:0] r_sat_acc;
    logic [1:0]  w_nclamp;
    logic [15:0] w_sat_base;
    logic [16:0] w_sat_sum;
    logic        w_eof_done;

    // A pixel accepted on the eof handshake belongs to the next frame.
    assign w_eof_done = w_r_done & bus.out_eof;
    assign w_nclamp   = {1'b0, w_clamp_b} + {1'b0, w_clamp_g} +
                        {1'b0, w_clamp_r};
    assign w_sat_base = w_eof_done ? 16'h0000 : r_sat_acc;
    assign w_sat_sum  = {1'b0, w_sat_base} +
                        (w_accept ? {15'd0, w_nclamp} : 17'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_acc <= 16'h0000;
            sat_count <= 16'h0000;
        end else begin
            r_sat_acc <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
            if (w_eof_done) sat_count <= r_sat_acc;
        end
    end
`endif
endmodule

// File: tb/tb_bgr_stream_packer.sv
// Directed bench for bgr_stream_packer with a queue-based byte model.
// Runs a 2x3 frame so framing wraps are exercised often.
module tb_bgr_stream_packer;
    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int NPIX = ROWS * COLS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
`ifdef BGR_STREAM_PACKER_SATCNT_EN
    logic [15:0] sat_count;
`endif

    always #5 clk = ~clk;

    bgr_stream_packer_if #(.ACC_W(24)) bus ();

    bgr_stream_packer #(
        .ROWS(ROWS), .COLS(COLS), .ACC_W(24), .NORM_SHIFT(12)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy)
`ifdef BGR_STREAM_PACKER_SATCNT_EN
        ,
        .sat_count(sat_count)
`endif
    );

    typedef struct packed {
        logic [7:0] b;
        logic       sof;
        logic       eol;
        logic       eof;
    } ent_t;

    ent_t q[$];
    ent_t cap[$];
    int errors = 0;
    int checks = 0;
    int p = 0;
    int cyc = 0;
    int first_v = -1;
    int last_v = -1;
    int unsigned scnt = 0;
    int unsigned exp_sat = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int unsigned chv(input logic [23:0] s);
        return s / 4096;
    endfunction

    function automatic logic [7:0] norm(input logic [23:0] s);
        int unsigned v;
        v = chv(s);
        return (v > 255) ? 8'hFF : 8'(v);
    endfunction

    // Reference model: each accepted pixel expands to three queued bytes.
    always @(negedge clk) begin : model
        ent_t e;
        int row;
        int col;
        int unsigned cl;
        cyc++;
        if (rst) begin
            q.delete();
            p = 0;
            scnt = 0;
            exp_sat = 0;
        end else begin
`ifdef BGR_STREAM_PACKER_SATCNT_EN
            chk("sat_count", sat_count, exp_sat);
`endif
            chk("out_valid", bus.out_valid, q.size() != 0);
            chk("busy", busy, q.size() != 0);
            chk("in_ready", bus.in_ready,
                (q.size() == 0) || (q.size() == 1 && bus.out_ready));
            if (bus.out_valid && q.size() != 0)
                chk("byte_flags", {bus.out_byte, bus.out_sof,
                                   bus.out_eol, bus.out_eof}, q[0]);
            if (bus.out_valid) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (bus.out_valid && bus.out_ready) begin
                cap.push_back({bus.out_byte, bus.out_sof,
                               bus.out_eol, bus.out_eof});
                if (q.size() != 0) begin
                    e = q.pop_front();
                    if (e.eof) begin
                        exp_sat = scnt;
                        scnt = 0;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                row = p / COLS;
                col = p % COLS;
                cl = 0;
                if (chv(bus.in_sum_b) > 255) cl++;
                if (chv(bus.in_sum_g) > 255) cl++;
                if (chv(bus.in_sum_r) > 255) cl++;
                scnt = (scnt + cl > 65535) ? 65535 : scnt + cl;
                q.push_back({norm(bus.in_sum_b), p == 0, 1'b0, 1'b0});
                q.push_back({norm(bus.in_sum_g), 1'b0, 1'b0, 1'b0});
                q.push_back({norm(bus.in_sum_r), 1'b0, col == COLS - 1,
                             (row == ROWS - 1) && (col == COLS - 1)});
                p = (p + 1) % NPIX;
            end
        end
    end

    task automatic send(input logic [23:0] b, input logic [23:0] g,
                        input logic [23:0] r);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_sum_b = b;
        bus.in_sum_g = g;
        bus.in_sum_r = r;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        chk("send_accept", acc, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_idle", bus.out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sum_b  = '0;
        bus.in_sum_g  = '0;
        bus.in_sum_r  = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_byte", bus.out_byte, 8'h00);
        chk("rst_flags", {bus.out_sof, bus.out_eol, bus.out_eof}, 3'b000);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Single pixel: latency and byte order.
        cap.delete();
        send(24'h00A000, 24'h07F000, 24'h0FF000);
        @(negedge clk);
        chk("t1_latency_valid", bus.out_valid, 1);
        chk("t1_latency_byte", bus.out_byte, 8'h0A);
        @(posedge clk);
        #1;
        drain();
        chk("t1_count", cap.size(), 3);
        if (cap.size() == 3) begin
            chk("t1_b", cap[0].b, 8'h0A);
            chk("t1_g", cap[1].b, 8'h7F);
            chk("t1_r", cap[2].b, 8'hFF);
            chk("t1_sof", {cap[0].sof, cap[1].sof, cap[2].sof}, 3'b100);
        end
        chk("t1_busy_after", busy, 0);

        // Saturation.
        cap.delete();
        send(24'h100000, 24'hFFFFFF, 24'h0FFFFF);
        drain();
        chk("t2_count", cap.size(), 3);
        if (cap.size() == 3)
            chk("t2_bytes", {cap[0].b, cap[1].b, cap[2].b}, 24'hFFFFFF);

        // Backpressure on the G byte.
        send(24'h001000, 24'h07F000, 24'h020000);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sum_b  = 24'h003000;
        bus.in_sum_g  = 24'h004000;
        bus.in_sum_r  = 24'h005000;
        repeat (5) begin
            @(negedge clk);
            chk("t3_hold_byte", bus.out_byte, 8'h7F);
            chk("t3_hold_valid", bus.out_valid, 1);
            chk("t3_hold_ready", bus.in_ready, 0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t3_r_byte", bus.out_byte, 8'h20);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();

        // Framing over a 2x3 frame plus one pixel.
        pulse_rst();
        cap.delete();
        for (int k = 0; k < 7; k++) begin
            if (k == 0) send(24'h100000, 24'h200000, 24'h001000);
            else send(24'(k * 24'h1000), 24'(k * 24'h2000),
                      24'(k * 24'h4000));
        end
        drain();
        chk("t4_count", cap.size(), 21);
        if (cap.size() == 21) begin
            for (int i = 0; i < 21; i++) begin
                chk("t4_sof", cap[i].sof, (i == 0) || (i == 18));
                chk("t4_eol", cap[i].eol, (i == 8) || (i == 17));
                chk("t4_eof", cap[i].eof, i == 17);
            end
        end
`ifdef BGR_STREAM_PACKER_SATCNT_EN
        chk("t4_sat_count", sat_count, 16'd2);
`endif

        // Back-to-back throughput.
        pulse_rst();
        cap.delete();
        first_v = -1;
        last_v = -1;
        for (int k = 0; k < 100; k++)
            send(24'(k * 24'h1000), 24'(k * 24'h3000),
                 24'hFFFFFF - 24'(k * 24'h7000));
        drain();
        chk("t5_bytes", cap.size(), 300);
        chk("t5_span", last_v - first_v + 1, 300);

        // Reset right after the B handshake of pixel (0,1).
        pulse_rst();
        send(24'h011000, 24'h022000, 24'h033000);
        send(24'h044000, 24'h055000, 24'h066000);
        @(posedge clk);
        #1;
        pulse_rst();
        @(negedge clk);
        chk("t6_valid_drop", bus.out_valid, 0);
        chk("t6_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        cap.delete();
        send(24'h077000, 24'h088000, 24'h099000);
        drain();
        chk("t6_count", cap.size(), 3);
        if (cap.size() == 3) begin
            chk("t6_sof", cap[0].sof, 1);
            chk("t6_b", cap[0].b, 8'h77);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
